irs2_tsa_servo: RTL and testbench

IRS2_TSA_SERVO -- requirements
Module: irs2_tsa_servo

---
 rtl/irs2_tsa_servo.sv | 230 +++++++++++++++++++++++
 tb/tb_irs2_tsa_servo.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irs2_tsa_servo.sv
// IRS2 TSA phase servo.
// Periodically triggers the sample-speed monitor and averages 2^AVG_LOG2
// phase readings relative to the target. It then nudges the Vdly DAC code
// by STEP whenever the averaged error leaves the deadband, and hands the
// new code to the DAC loader with a one-cycle strobe.
module irs2_tsa_servo #(
    parameter int unsigned PERIOD_CYCLES  = 1000000,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned DEADBAND       = 2,
    parameter int unsigned STEP           = 1,
    parameter logic [11:0] INIT_VDLY      = 12'd2048
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        present_i,
    input  logic        servo_en_i,
    input  logic [7:0]  target_i,
    output logic        mon_enable_o,
    input  logic        mon_done_i,
    input  logic [7:0]  mon_phase_i,
    output logic [11:0] vdly_o,
    output logic        vdly_load_o,
    input  logic        dac_busy_i,
    output logic [7:0]  avg_phase_o,
    output logic        valid_o,
    output logic        timeout_o,
    input  logic        timeout_clr_i
);

    // One down-counter serves both the period wait and the monitor timeout,
    // so it is sized for the larger of the two.
    localparam int unsigned MAX_CYCLES = (PERIOD_CYCLES > TIMEOUT_CYCLES) ? PERIOD_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TMR_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int unsigned CNT_W      = AVG_LOG2 + 1;
    localparam int unsigned ACC_W      = 8 + AVG_LOG2;

    localparam logic [TMR_W-1:0] PERIOD_LOAD  = TMR_W'(PERIOD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic signed [9:0] DB_POS      = 10'(DEADBAND);
    localparam logic signed [9:0] DB_NEG      = 10'sd0 - DB_POS;
    localparam logic [12:0]       STEP_W      = 13'(STEP);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PERIOD,
        TRIG,
        WAIT_DONE,
        ACCUM,
        EVAL,
        LOAD,
        LOAD_WAIT
    } state_t;

    state_t                   state_q, state_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [11:0]              vdly_q, vdly_d;
    logic [7:0]               avg_q, avg_d;
    logic                     valid_q, valid_d;
    logic                     load_q, load_d;
    logic                     timeout_q, timeout_d;
    logic                     timeout_set;

    // Datapath helpers
    logic [7:0]               offset;
    logic signed [ACC_W-1:0]  offset_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  acc_shift;
    logic signed [7:0]        err;
    logic signed [9:0]        err_ext;
    logic [12:0]              vdly_up;
    logic [12:0]              vdly_dn;
    logic [11:0]              vdly_new;
    logic [7:0]               avg_new;

    // Modular difference reinterpreted as signed gives the shortest circular
    // distance, so readings straddling 0/255 average correctly.
    assign offset     = mon_phase_i - target_i;
    assign offset_ext = ACC_W'($signed(offset));
    assign acc_sum    = acc_q + offset_ext;
    assign acc_shift  = acc_q >>> AVG_LOG2;
    assign err        = acc_shift[7:0];
    assign err_ext    = 10'(err);
    assign avg_new    = target_i + $unsigned(err);
    assign vdly_up    = {1'b0, vdly_q} + STEP_W;
    assign vdly_dn    = {1'b0, vdly_q} - STEP_W;

    // Saturating correction: a phase ahead of target slows the delay line
    // down (lower code), a phase behind speeds it up.
    always_comb begin
        vdly_new = vdly_q;
        if (err_ext > DB_POS) begin
            vdly_new = vdly_dn[12] ? 12'd0 : vdly_dn[11:0];
        end else if (err_ext < DB_NEG) begin
            vdly_new = (vdly_up > 13'd4095) ? 12'hFFF : vdly_up[11:0];
        end
    end

    // Next-state logic and all register updates for the servo loop.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        vdly_d      = vdly_q;
        avg_d       = avg_q;
        valid_d     = 1'b0;
        load_d      = 1'b0;
        timeout_set = 1'b0;

        if (!present_i || !servo_en_i) begin
            // Abort from anywhere: drop partial averages, keep the DAC code.
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_PERIOD;
                    timer_d = PERIOD_LOAD;
                end
                WAIT_PERIOD: begin
                    if (timer_q == '0) begin
                        state_d = TRIG;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                TRIG: begin
                    timer_d = TIMEOUT_LOAD;
                    state_d = WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A completion on the last allowed cycle is still accepted.
                    if (mon_done_i) begin
                        state_d = ACCUM;
                    end else if (timer_q == '0) begin
                        timeout_set = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = WAIT_PERIOD;
                        timer_d     = PERIOD_LOAD;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                ACCUM: begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = EVAL;
                    end else begin
                        state_d = WAIT_PERIOD;
                        timer_d = PERIOD_LOAD;
                    end
                end
                EVAL: begin
                    avg_d   = avg_new;
                    valid_d = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    if (vdly_new != vdly_q) begin
                        vdly_d  = vdly_new;
                        state_d = LOAD;
                    end else begin
                        state_d = WAIT_PERIOD;
                        timer_d = PERIOD_LOAD;
                    end
                end
                LOAD: begin
                    if (!dac_busy_i) begin
                        load_d  = 1'b1;
                        state_d = LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    state_d = WAIT_PERIOD;
                    timer_d = PERIOD_LOAD;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Sticky flag: a fresh timeout beats a simultaneous clear.
        timeout_d = timeout_q;
        if (timeout_set) begin
            timeout_d = 1'b1;
        end else if (timeout_clr_i) begin
            timeout_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            vdly_q    <= INIT_VDLY;
            avg_q     <= 8'd0;
            valid_q   <= 1'b0;
            load_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            vdly_q    <= vdly_d;
            avg_q     <= avg_d;
            valid_q   <= valid_d;
            load_q    <= load_d;
            timeout_q <= timeout_d;
        end
    end

    assign mon_enable_o = (state_q == TRIG);
    assign vdly_o       = vdly_q;
    assign vdly_load_o  = load_q;
    assign avg_phase_o  = avg_q;
    assign valid_o      = valid_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_irs2_tsa_servo.sv
// Scoreboard bench for irs2_tsa_servo: directed phase batches with
// hand-computed averages and DAC codes, plus timing, abort and reset cases.
`timescale 1ns/1ps
module tb_irs2_tsa_servo;

    localparam int P = 10;
    localparam int T = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       present = 1'b1;
    logic       en_m = 1'b0;
    logic       en_s = 1'b0;
    logic       mon_done = 1'b0;
    logic [7:0] mon_phase = 8'd0;
    logic       busy = 1'b0;
    logic       tclr = 1'b0;
    logic [7:0] tgt_m = 8'd0;
    logic [7:0] tgt_lo = 8'd0;
    logic [7:0] tgt_hi = 8'd0;

    logic        mon_en_m, load_m, valid_m, tmo_m;
    logic [11:0] vdly_m;
    logic [7:0]  avg_m;
    logic        mon_en_lo, load_lo, valid_lo, tmo_lo;
    logic [11:0] vdly_lo;
    logic [7:0]  avg_lo;
    logic        mon_en_hi, load_hi, valid_hi, tmo_hi;
    logic [11:0] vdly_hi;
    logic [7:0]  avg_hi;

    irs2_tsa_servo #(.PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T), .AVG_LOG2(2), .DEADBAND(2),
                     .STEP(1), .INIT_VDLY(12'd2048)) u_main (
        .clk_i(clk), .rst_i(rst), .present_i(present), .servo_en_i(en_m), .target_i(tgt_m),
        .mon_enable_o(mon_en_m), .mon_done_i(mon_done), .mon_phase_i(mon_phase),
        .vdly_o(vdly_m), .vdly_load_o(load_m), .dac_busy_i(busy), .avg_phase_o(avg_m),
        .valid_o(valid_m), .timeout_o(tmo_m), .timeout_clr_i(tclr));

    irs2_tsa_servo #(.PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T), .AVG_LOG2(2), .DEADBAND(2),
                     .STEP(1), .INIT_VDLY(12'd0)) u_lo (
        .clk_i(clk), .rst_i(rst), .present_i(present), .servo_en_i(en_s), .target_i(tgt_lo),
        .mon_enable_o(mon_en_lo), .mon_done_i(mon_done), .mon_phase_i(mon_phase),
        .vdly_o(vdly_lo), .vdly_load_o(load_lo), .dac_busy_i(busy), .avg_phase_o(avg_lo),
        .valid_o(valid_lo), .timeout_o(tmo_lo), .timeout_clr_i(tclr));

    irs2_tsa_servo #(.PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T), .AVG_LOG2(2), .DEADBAND(2),
                     .STEP(1), .INIT_VDLY(12'd4095)) u_hi (
        .clk_i(clk), .rst_i(rst), .present_i(present), .servo_en_i(en_s), .target_i(tgt_hi),
        .mon_enable_o(mon_en_hi), .mon_done_i(mon_done), .mon_phase_i(mon_phase),
        .vdly_o(vdly_hi), .vdly_load_o(load_hi), .dac_busy_i(busy), .avg_phase_o(avg_hi),
        .valid_o(valid_hi), .timeout_o(tmo_hi), .timeout_clr_i(tclr));

    typedef struct {
        int avg;
        int vdly;
    } exp_t;

    exp_t q_m[$];
    exp_t q_lo[$];
    exp_t q_hi[$];
    exp_t mon_e;
    int   phase_q[$];
    int   resp_delay = 2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_load_m = 0;
    int n_load_lo = 0;
    int n_load_hi = 0;
    int n_valid_m = 0;
    int n_trig_m = 0;
    int trig_cyc[$];
    int last_load_cyc = -1;
    int tmo_rise = -1;
    logic tmo_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endfunction

    // Monitor: pops the scoreboard on every valid_o and tallies strobes/triggers.
    always @(negedge clk) begin
        if (valid_m) begin
            n_valid_m++;
            if (q_m.size() == 0) begin
                total++; bad++;
                $display("FAIL main_unexpected_valid: got avg %0d with no expectation", avg_m);
            end else begin
                mon_e = q_m.pop_front();
                chk("main_avg", int'(avg_m), mon_e.avg);
                chk("main_vdly", int'(vdly_m), mon_e.vdly);
            end
        end
        if (valid_lo) begin
            if (q_lo.size() == 0) begin
                total++; bad++;
                $display("FAIL lo_unexpected_valid: got avg %0d with no expectation", avg_lo);
            end else begin
                mon_e = q_lo.pop_front();
                chk("lo_avg", int'(avg_lo), mon_e.avg);
                chk("lo_vdly", int'(vdly_lo), mon_e.vdly);
            end
        end
        if (valid_hi) begin
            if (q_hi.size() == 0) begin
                total++; bad++;
                $display("FAIL hi_unexpected_valid: got avg %0d with no expectation", avg_hi);
            end else begin
                mon_e = q_hi.pop_front();
                chk("hi_avg", int'(avg_hi), mon_e.avg);
                chk("hi_vdly", int'(vdly_hi), mon_e.vdly);
            end
        end
        if (load_m) begin
            n_load_m++;
            last_load_cyc = cyc;
        end
        if (load_lo) n_load_lo++;
        if (load_hi) n_load_hi++;
        if (mon_en_m) begin
            n_trig_m++;
            trig_cyc.push_back(cyc);
        end
        if (tmo_m && !tmo_prev) tmo_rise = cyc;
        tmo_prev = tmo_m;
    end

    // Monitor model: answers each trigger with the next queued phase.
    int resp_p;
    initial begin
        forever begin
            @(negedge clk);
            if ((mon_en_m || mon_en_lo || mon_en_hi) && phase_q.size() > 0) begin
                resp_p = phase_q.pop_front();
                repeat (resp_delay) @(posedge clk);
                #1;
                mon_done  = 1'b1;
                mon_phase = 8'(resp_p);
                @(posedge clk);
                #1;
                mon_done  = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((q_m.size() + q_lo.size() + q_hi.size() + phase_q.size()) != 0 && k < 3000) begin
            tick(1);
            k++;
        end
        total++;
        if (k >= 3000) begin
            bad++;
            $display("FAIL %s_drain: %0d expectations left after %0d cycles, required 0",
                     name, q_m.size() + q_lo.size() + q_hi.size(), k);
        end
    endtask

    task automatic wait_trig(input string name, input int n);
        int k = 0;
        while (n_trig_m < n && k < 500) begin
            tick(1);
            k++;
        end
        total++;
        if (n_trig_m < n) begin
            bad++;
            $display("FAIL %s_trig: trigger count %0d expected %0d", name, n_trig_m, n);
        end
    endtask

    task automatic push_m(input int tgt, input int p0, input int p1, input int p2, input int p3,
                          input int eavg, input int evdly);
        exp_t x;
        tgt_m = 8'(tgt);
        phase_q.push_back(p0);
        phase_q.push_back(p1);
        phase_q.push_back(p2);
        phase_q.push_back(p3);
        x.avg  = eavg;
        x.vdly = evdly;
        q_m.push_back(x);
    endtask

    task automatic run_batch(input string name, input int tgt, input int p0, input int p1,
                             input int p2, input int p3, input int eavg, input int evdly,
                             input int eloads);
        push_m(tgt, p0, p1, p2, p3, eavg, evdly);
        en_m = 1'b1;
        wait_drain(name);
        tick(4);
        en_m = 1'b0;
        tick(2);
        chk({name, "_loads"}, n_load_m, eloads);
        chk({name, "_vdly_hold"}, int'(vdly_m), evdly);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base;
    int fall_cyc;
    int r_cyc;
    int nv;
    exp_t xs;

    initial begin
        tick(5);
        rst = 1'b0;
        tick(1);
        chk("rst_vdly_main", int'(vdly_m), 2048);
        chk("rst_vdly_lo", int'(vdly_lo), 0);
        chk("rst_vdly_hi", int'(vdly_hi), 4095);
        chk("rst_avg", int'(avg_m), 0);
        chk("rst_timeout", int'(tmo_m), 0);
        chk("rst_valid", int'(valid_m), 0);
        chk("rst_load", int'(load_m), 0);
        chk("rst_mon_en", int'(mon_en_m), 0);

        // Nominal, wrap-around, floor rounding, deadband edge, signed extreme.
        run_batch("nominal", 100, 104, 104, 104, 104, 104, 2047, 1);
        run_batch("wrap",      2, 254, 254,   6,   6,   2, 2047, 1);
        run_batch("floor",    50,  47,  47,  47,  48,  47, 2048, 2);
        run_batch("deadband", 200, 202, 202, 202, 202, 202, 2048, 2);
        run_batch("extreme",  10, 138, 138, 138, 138, 138, 2049, 3);

        // DAC busy held 20 cycles while in LOAD.
        busy = 1'b1;
        push_m(0, 5, 5, 5, 5, 5, 2048);
        en_m = 1'b1;
        wait_drain("busy");
        tick(20);
        chk("busy_no_strobe", n_load_m, 3);
        busy = 1'b0;
        fall_cyc = cyc;
        tick(4);
        chk("busy_loads", n_load_m, 4);
        chk("busy_strobe_delay", last_load_cyc - fall_cyc, 1);
        chk("busy_vdly", int'(vdly_m), 2048);
        en_m = 1'b0;
        tick(2);

        // Abort in WAIT_DONE after two samples; the partial sum must be discarded.
        tgt_m = 8'd30;
        phase_q.push_back(50);
        phase_q.push_back(50);
        nv = n_valid_m;
        base = n_trig_m;
        en_m = 1'b1;
        wait_trig("abort", base + 3);
        tick(3);
        en_m = 1'b0;
        tick(4);
        chk("abort_no_valid", n_valid_m, nv);
        chk("abort_no_strobe", n_load_m, 4);
        chk("abort_vdly", int'(vdly_m), 2048);
        push_m(30, 34, 34, 34, 34, 34, 2047);
        base = n_trig_m;
        r_cyc = cyc;
        en_m = 1'b1;
        wait_trig("restart", base + 1);
        if (trig_cyc.size() > 0) chk("restart_latency", trig_cyc[trig_cyc.size() - 1] - r_cyc, P + 1);
        wait_drain("abort_resume");
        tick(4);
        en_m = 1'b0;
        tick(2);
        chk("abort_resume_loads", n_load_m, 5);

        // Monitor completion on the final timeout cycle is accepted.
        resp_delay = T;
        run_batch("lastcycle", 77, 77, 77, 77, 77, 77, 2047, 5);
        chk("lastcycle_timeout", int'(tmo_m), 0);
        resp_delay = 2;

        // Timeout: no completion ever arrives.
        nv = n_valid_m;
        base = n_trig_m;
        tmo_rise = -1;
        en_m = 1'b1;
        wait_trig("timeout", base + 2);
        en_m = 1'b0;
        tick(2);
        if (trig_cyc.size() >= base + 2) begin
            chk("timeout_set_delay", tmo_rise - trig_cyc[base], T + 1);
            chk("timeout_retrigger", trig_cyc[base + 1] - trig_cyc[base], T + P + 1);
        end
        chk("timeout_no_valid", n_valid_m, nv);
        chk("timeout_sticky", int'(tmo_m), 1);
        tclr = 1'b1;
        tick(1);
        tclr = 1'b0;
        chk("timeout_cleared", int'(tmo_m), 0);

        // Saturation at both ends of the DAC range.
        tgt_lo = 8'd50;
        tgt_hi = 8'd70;
        for (int i = 0; i < 4; i++) phase_q.push_back(60);
        xs.avg = 60; xs.vdly = 0;
        q_lo.push_back(xs);
        xs.avg = 60; xs.vdly = 4095;
        q_hi.push_back(xs);
        en_s = 1'b1;
        wait_drain("sat");
        tick(4);
        en_s = 1'b0;
        tick(2);
        chk("sat_lo_loads", n_load_lo, 0);
        chk("sat_hi_loads", n_load_hi, 0);
        chk("sat_lo_vdly", int'(vdly_lo), 0);
        chk("sat_hi_vdly", int'(vdly_hi), 4095);

        // Reset while a load is pending.
        busy = 1'b1;
        push_m(0, 8, 8, 8, 8, 8, 2046);
        en_m = 1'b1;
        wait_drain("rstload");
        tick(2);
        rst  = 1'b1;
        en_m = 1'b0;
        tick(3);
        rst  = 1'b0;
        busy = 1'b0;
        tick(3);
        chk("rstload_vdly", int'(vdly_m), 2048);
        chk("rstload_avg", int'(avg_m), 0);
        chk("rstload_no_strobe", n_load_m, 5);
        chk("rstload_timeout", int'(tmo_m), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
